// File: rtl/seq_detect_param.sv
// Parametrised Moore serial-pattern detector with valid qualifier, saturating match
// counter and synchronous clear. Define SEQ_DET_MASK_EN to add the pat_mask don't-care port.
module seq_detect_param #(
    parameter int unsigned      PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1010,
    parameter bit               OVERLAP = 1'b1,
    parameter int unsigned      CNT_W   = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in,
`ifdef SEQ_DET_MASK_EN
    input  logic [PAT_W-1:0] pat_mask,
`endif
    output logic             out,
    output logic [CNT_W-1:0] match_count,
    output logic             hist_full
);

    localparam int unsigned       FILL_W   = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;

    logic [PAT_W-1:0]  hist, hist_n, hist_shift, cmp_mask;
    logic [FILL_W-1:0] fill, fill_n, fill_inc;
    logic [CNT_W-1:0]  count_n;
    logic              out_n, match;

`ifdef SEQ_DET_MASK_EN
    assign cmp_mask = pat_mask;
`else
    assign cmp_mask = '1;
`endif

    // fill gates the compare so the zeroed history after reset/clr can never
    // stand in for real bits (matters for patterns such as all-zeros).
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        hist_shift = {hist[PAT_W-2:0], in};
        fill_inc   = (fill == FILL_MAX) ? FILL_MAX : fill + 1'b1;
        match      = (fill_inc == FILL_MAX) && (((hist_shift ^ PATTERN) & cmp_mask) == '0);
        hist_n     = hist;
        fill_n     = fill;
        out_n      = 1'b0;
        count_n    = match_count;

        if (clr) begin
            hist_n  = '0;
            fill_n  = '0;
            count_n = '0;
        end else if (in_valid) begin
            out_n = match;
            if (match && (match_count != CNT_MAX))
                count_n = match_count + 1'b1;
            if (match && !OVERLAP) begin
                hist_n = '0;
                fill_n = '0;
            end else begin
                hist_n = hist_shift;
                fill_n = fill_inc;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        // NOTE: state flops use non-blocking assignment so all registers update from pre-edge values.
        if (!reset) begin
            hist        <= '0;
            fill        <= '0;
            out         <= 1'b0;
            match_count <= '0;
            hist_full   <= 1'b0;
        end else begin
            hist        <= hist_n;
            fill        <= fill_n;
            out         <= out_n;
            match_count <= count_n;
            hist_full   <= (fill_n == FILL_MAX);
        end
    end

endmodule

// File: doc/seq_detect_param.md
Name: seq_detect_param

Overview:
- Parametrised Moore serial-pattern detector, successor to the fixed 4-bit "1010" detector.
- Pattern value, pattern length, overlap mode and match-counter width are all parameters.
- Adds an input-valid qualifier, a saturating match counter and a synchronous clear.
- Sits on a single-bit serial stream; its registered pulse output feeds downstream control or status logic.

Parameters:
- PAT_W, 4, pattern length in bits (legal range 2..16).
- PATTERN, 4'b1010, PAT_W-bit target pattern. MSB is the oldest bit received.
- OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (reset=0 asserts immediately; release is synchronous to clk by the system).
- clr  input  1  synchronous clear of history, fill and counter.
- in_valid  input  1  qualifies in; bit consumed only when high.
- in  input  1  serial data bit.
- out  output  1  registered match pulse (Moore; driven only from a flop).
- match_count  output  CNT_W  saturating count of matches since reset/clr.
- hist_full  output  1  high when PAT_W valid bits are held in history.

Behaviour:
- Reset (reset=0, asynchronous): hist=0, fill=0, out=0, match_count=0, hist_full=0.
- State: hist[PAT_W-1:0] is the shift history; fill[ceil(log2(PAT_W+1))-1:0] counts valid bits held (0..PAT_W).
- Per rising edge, priority order:
  1. clr=1: hist=0, fill=0, match_count=0, out=0. in is ignored that cycle.
  2. in_valid=0: hist and fill hold, out=0, count holds.
  3. in_valid=1:
     - hist_n={hist[PAT_W-2:0],in}; fill_n=min(fill+1,PAT_W).
     - match = (fill_n==PAT_W) && (hist_n==PATTERN).
     - out<=match.
     - match_count<=match_count+1 if match and match_count != 2^CNT_W-1; otherwise hold (saturate, no wrap).
     - OVERLAP=1: hist<=hist_n, fill<=fill_n.
     - OVERLAP=0 and match: hist<=0, fill<=0. Otherwise same as OVERLAP=1.
- Latency: out is high in the cycle after the edge that sampled the final pattern bit. Width is exactly one cycle per match; back-to-back pulses are legal (e.g. PATTERN=11, stream 111).
- No match is possible before PAT_W valid bits are accepted since reset/clr. Pre-reset zeros in hist must never produce a false match (e.g. PATTERN=0000).
- hist_full = (fill==PAT_W), registered.
- in_valid gaps are transparent: a pattern split by invalid cycles still matches.
- Reset mid-stream aborts any partial match immediately. clr asserted in the same cycle as a would-be match: clr wins, out=0, count=0.

Optional Feature:
- Macro: SEQ_DET_MASK_EN.
- Defined:
  - Adds input port pat_mask[PAT_W-1:0].
  - Match becomes (fill_n==PAT_W) && (((hist_n ^ PATTERN) & pat_mask)==0); mask bit 0 = don't-care.
  - All-zero mask matches every accepted bit once fill_n==PAT_W.
- Undefined: the port is absent and all bits are compared (equivalent to an all-ones mask).

Test Plan:
- Overlap default: reset low 10 ns then released; in_valid=1, stream 0,1,0,1,0,1,1,0,1,0 -> out pulses after bit 5 and bit 10 only; match_count=2.
- OVERLAP=1 vs OVERLAP=0, stream 1,0,1,0,1,0 -> OVERLAP=1 pulses after bits 4 and 6 (count=2); OVERLAP=0 pulses after bit 4 only (count=1).
- Valid gaps: stream 1,0 then in_valid=0 for 3 cycles with in=1, then 1,0 -> single pulse after the last bit; no pulse during the gap.
- False-match guard: PATTERN=4'b0000; after reset send 0,0,0 -> out=0, hist_full=0; send a 4th 0 -> pulse, count=1.
- Saturation and clear: CNT_W=2, drive 5 overlapping matches -> match_count sticks at 3. Then clr=1 coincident with a completing bit -> out=0, match_count=0, hist_full=0.
- Async reset mid-pattern: after 1,0,1 assert reset=0 between clock edges -> out/count/hist_full drop immediately. Release, send 0 -> no pulse.
